// File: rtl/fir_ram_in_processor.sv
// ----------------------------------------------------------------------------
// fir_ram_in_processor
//   Input side of a RAM-based FIR filter. Accepted samples are written into a
//   circular delay line; each accepted sample then triggers a TAPS-long stream
//   of (sample, coefficient index) pairs, newest sample first, for a
//   downstream MAC.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   data_i       signed input sample
//   valid_i      data_i valid this cycle
//   ready_o      sample can be accepted this cycle (IDLE only)
//   overrun_o    one-cycle pulse: a sample was offered while busy and dropped
//   sample_o     delay-line sample for the MAC
//   coef_addr_o  coefficient index paired with sample_o
//   valid_o      sample_o / coef_addr_o valid
//   first_o      tap 0 of a convolution (clear accumulator)
//   last_o       tap TAPS-1 of a convolution (result complete)
// ----------------------------------------------------------------------------
module fir_ram_in_processor #(
    parameter int IWIDTH = 16,
    parameter int TAPS   = 32,
    localparam int AWIDTH = $clog2(TAPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [IWIDTH-1:0] data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic                     overrun_o,
    output logic signed [IWIDTH-1:0] sample_o,
    output logic        [AWIDTH-1:0] coef_addr_o,
    output logic                     valid_o,
    output logic                     first_o,
    output logic                     last_o
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ
    } state_t;

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(TAPS - 1);

    state_t                    state;
    logic signed [IWIDTH-1:0]  mem [TAPS];
    logic        [AWIDTH-1:0]  wp;
    logic        [AWIDTH-1:0]  rp;
    logic        [AWIDTH-1:0]  cnt;

    assign ready_o = (state == IDLE);

    // Delay line has no reset; INIT sweeps it to zero one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            mem[wp] <= '0;
        end else if (state == IDLE && valid_i) begin
            mem[wp] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= INIT;
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            sample_o    <= '0;
            coef_addr_o <= '0;
            valid_o     <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            // Any offer outside IDLE is dropped and flagged next cycle.
            overrun_o <= valid_i && (state != IDLE);

            case (state)
                INIT: begin
                    // wp doubles as the clear index and ends back at 0.
                    if (wp == LAST) begin
                        wp    <= '0;
                        state <= IDLE;
                    end else begin
                        wp <= wp + 1'b1;
                    end
                end

                IDLE: begin
                    valid_o <= 1'b0;
                    first_o <= 1'b0;
                    last_o  <= 1'b0;
                    if (valid_i) begin
                        rp    <= wp;
                        cnt   <= '0;
                        state <= READ;
                    end
                end

                READ: begin
                    sample_o    <= mem[rp];
                    coef_addr_o <= cnt;
                    valid_o     <= 1'b1;
                    first_o     <= (cnt == '0);
                    last_o      <= (cnt == LAST);
                    // Walk backwards in time: newest sample pairs with coef 0.
                    rp          <= (rp == '0) ? LAST : rp - 1'b1;
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        wp    <= (wp == LAST) ? '0 : wp + 1'b1;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

endmodule
